// File: rtl/rotate_pos_gen_if.sv
// Control and status bundle for the rotating-position generator.
// The master drives the rotation controls; the slave returns position and lap status.
interface rotate_pos_gen_if;
    logic       en;
    logic       cw;
    logic       step;
    logic [1:0] speed;
    logic       lap_clr;
    logic [2:0] pos;
    logic       tick;
    logic       lap;
    logic [7:0] lap_cnt;

    modport master (
        output en, cw, step, speed, lap_clr,
        input  pos, tick, lap, lap_cnt
    );

    modport slave (
        input  en, cw, step, speed, lap_clr,
        output pos, tick, lap, lap_cnt
    );
endinterface

// File: rtl/rotate_pos_gen.sv
// Rotation index generator for a segment pattern driver: free-running or single-step
// advance of a 0..7 position, with lap detection and a saturating lap counter.
module rotate_pos_gen #(
    parameter int TICK_DIV = 25_000_000,
    parameter int CNT_W    = 25
) (
    input  logic              clk,
    input  logic              reset,
    rotate_pos_gen_if.slave   bus
);

    typedef enum logic {HOLD, RUN} state_t;

    localparam logic [CNT_W-1:0] DIV = CNT_W'(TICK_DIV);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] presc, presc_nxt;
    logic [CNT_W-1:0] limit_m1;
    logic             step_q, step_arm;
    logic             advance, wrap;
    logic [2:0]       pos_r;
    logic             tick_r, lap_r;
    logic [7:0]       lap_cnt_r;

    assign limit_m1 = (DIV >> bus.speed) - CNT_W'(1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = bus.en ? RUN : HOLD;
        presc_nxt = '0;
        advance   = 1'b0;
        if (state == RUN) begin
            // ">=" also catches a speed increase that leaves the count past the new limit.
            if (presc >= limit_m1) advance = 1'b1;
            else                   presc_nxt = presc + CNT_W'(1);
        end else begin
            // step_arm masks a step that was already high when reset released.
            advance = step_arm && bus.step && !step_q && !bus.en;
        end
        wrap = advance && (bus.cw ? (pos_r == 3'd7) : (pos_r == 3'd0));
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HOLD;
            presc     <= '0;
            step_q    <= 1'b0;
            step_arm  <= 1'b0;
            pos_r     <= 3'd0;
            tick_r    <= 1'b0;
            lap_r     <= 1'b0;
            lap_cnt_r <= 8'd0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            step_q   <= bus.step;
            step_arm <= 1'b1;
            tick_r   <= advance;
            lap_r    <= wrap;
            if (advance) pos_r <= bus.cw ? pos_r + 3'd1 : pos_r - 3'd1;
            if (bus.lap_clr)                     lap_cnt_r <= 8'd0;
            else if (wrap && lap_cnt_r != 8'hFF) lap_cnt_r <= lap_cnt_r + 8'd1;
        end
    end

    assign bus.pos     = pos_r;
    assign bus.tick    = tick_r;
    assign bus.lap     = lap_r;
    assign bus.lap_cnt = lap_cnt_r;

endmodule

// File: doc/rotate_pos_gen.md
ROTATE_POS_GEN -- requirements
Module: rotate_pos_gen

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25_000_000, meaning base clocks per position advance (minimum 8).
REQ-002 SHALL have parameter CNT_W, default 25, meaning prescaler width, holding TICK_DIV-1.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  1 = free-running rotation, 0 = hold or single-step.
REQ-006 SHALL have port cw  input  1  direction; 1 = position increments, 0 = position decrements.
REQ-007 SHALL have port step  input  1  synchronous, debounced step request; acts on rising edge only.
REQ-008 SHALL have port speed  input  2  rate select; advance period = TICK_DIV >> speed clocks.
REQ-009 SHALL have port lap_clr  input  1  synchronous clear of lap_cnt.
REQ-010 SHALL have port pos  output  3  registered rotation index 0..7, consumed by the segment pattern driver.
REQ-011 SHALL have port tick  output  1  one-cycle pulse in the cycle pos first shows a new value.
REQ-012 SHALL have port lap  output  1  one-cycle pulse coincident with tick when pos wrapped.
REQ-013 SHALL have port lap_cnt  output  8  completed-lap count, saturating.

Function
REQ-014 SHALL implement two states: HOLD (en=0) and RUN (en=1); HOLD->RUN on en=1, RUN->HOLD on en=0, each evaluated every cycle.
REQ-015 SHALL, in RUN, run the prescaler 0..LIMIT-1 with LIMIT = TICK_DIV >> speed, and issue an advance when the prescaler equals LIMIT-1, then wrap it to 0.
REQ-016 SHALL hold the prescaler at 0 in HOLD, so the first advance after HOLD->RUN occurs exactly LIMIT cycles after en rises.
REQ-017 SHALL, if speed changes leaving prescaler >= new LIMIT-1, advance on the next cycle and clear the prescaler (no wrap through full range).
REQ-018 SHALL, in HOLD, issue one advance per rising edge of step (step registered internally; edge = step & ~step_q).
REQ-019 SHALL ignore step in RUN, including a step edge coincident with HOLD->RUN.
REQ-020 SHALL apply an advance as pos <= pos+1 mod 8 when cw=1, and pos <= pos-1 mod 8 when cw=0, using cw sampled in the advance cycle.
REQ-021 SHALL have one-cycle latency: pos, tick and lap update on the clock edge following the advance condition; no combinational input-to-output path.
REQ-022 SHALL assert lap on 7->0 with cw=1 or 0->7 with cw=0, and deassert tick/lap on every non-advance cycle.
REQ-023 SHALL increment lap_cnt on each lap, saturating at 255.
REQ-024 SHALL clear lap_cnt to 0 on lap_clr, with lap_clr taking priority over a simultaneous lap; lap output still pulses.
REQ-025 SHALL let a cw change take effect at the next advance only, without resetting the prescaler or pos.

Reset
REQ-026 SHALL, while reset=0, asynchronously force pos=0, tick=0, lap=0, lap_cnt=0, prescaler=0, step_q=0, state=HOLD.
REQ-027 SHALL, on reset assertion mid-rotation, abort any pending advance; after release, the first RUN advance occurs LIMIT cycles after the first cycle with en=1.
REQ-028 SHALL treat step held high across reset release as no edge.

Verification (TICK_DIV=8)
REQ-029 SHALL cover: reset release, en=1, cw=1, speed=0 -> tick every 8 cycles, pos 1,2..7,0; lap=1 and lap_cnt=1 at the 0.
REQ-030 SHALL cover: en=1, cw=0 from pos=0 -> first advance gives pos=7 with lap=1; speed=2 gives advance period 2 cycles.
REQ-031 SHALL cover: en=0, three step pulses (high 3 cycles each) -> pos 0->1->2->3, exactly 3 ticks; step in RUN -> no extra tick.
REQ-032 SHALL cover: speed 0->3 with prescaler=6 -> advance next cycle, then every 1 cycle.
REQ-033 SHALL cover: force 255 laps then one more -> lap_cnt stays 255; lap_clr with simultaneous lap -> lap_cnt=0.
REQ-034 SHALL cover: reset asserted mid-RUN at pos=5 -> all outputs 0 immediately (asynchronous, before next clk).
